// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_arb_pkg
// Description : Shared types and helpers for the register-bus arbiter.
//               Provides the arbiter state encoding and a width helper used
//               for owner/pointer and timeout-counter sizing.
// Revision    : 1.0  initial release
// ============================================================================
package reg_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        RCAP  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } arb_state_e;

    // Bits needed to hold values 0..n-1. Never returns less than 1 so that a
    // single requester or a zero timeout still yields a legal vector width.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : reg_arb_rr_pick
// Description : Combinational rotate-priority picker. Returns the first set
//               request bit at or after ptr, wrapping past NUM_REQ-1 to 0.
// Ports       : req   in  NUM_REQ   request vector
//               ptr   in  IDX_W     starting index (highest priority)
//               valid out 1         at least one request is set
//               idx   out IDX_W     index of the winning request
// Revision    : 1.0  initial release
// ============================================================================
module reg_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // One extra bit so ptr + k cannot overflow before the wrap subtraction.
    logic [IDX_W:0] s;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        s     = '0;
        // Scan from the lowest priority down so the highest-priority hit is
        // the last one written and therefore wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (s >= (IDX_W + 1)'(NUM_REQ)) begin
                s = s - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[s[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = s[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_arbiter
// Description : Shares one register-bank slave port between NUM_REQ masters
//               with round-robin arbitration, one transaction in flight,
//               per-master ack/err completion and a per-access ready timeout.
// Ports       : clk, rstn              clock / async active-low reset
//               req, req_wr            per-master request and direction
//               req_addr, req_wdata    packed per-master address / write data
//               ack, err               1-cycle completion pulses to the owner
//               rdata                  read data, valid with a read ack
//               busy                   transaction in flight
//               m_sel, m_wr, m_addr,
//               m_wdata                slave request side
//               m_rdata, m_ready       slave response side
// Revision    : 1.0  initial release
// ============================================================================
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             ack,
    output logic [NUM_REQ-1:0]             err,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           busy,
    output logic                           m_sel,
    output logic                           m_wr,
    output logic [ADDR_WIDTH-1:0]          m_addr,
    output logic [DATA_WIDTH-1:0]          m_wdata,
    input  logic [DATA_WIDTH-1:0]          m_rdata,
    input  logic                           m_ready
);

    localparam int               c_IDX_W = clog2(NUM_REQ);
    localparam int               c_CNT_W = clog2(TIMEOUT + 1);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_TMAX = c_CNT_W'(TIMEOUT);

    arb_state_e              state_q, state_d;
    logic [c_IDX_W-1:0]      owner_q, owner_d;
    logic [c_IDX_W-1:0]      ptr_q, ptr_d;
    logic [c_CNT_W-1:0]      cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [NUM_REQ-1:0]      err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    busy_q, busy_d;
    logic                    m_sel_q, m_sel_d;
    logic                    m_wr_q, m_wr_d;
    logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;

    logic                    pick_valid;
    logic [c_IDX_W-1:0]      pick_idx;

    reg_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    wr_d    = req_wr[pick_idx];
                    addr_d  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Acceptance wins over timeout on the same edge.
                if (m_ready) begin
                    state_d = wr_q ? DONE : RCAP;
                end else if ((TIMEOUT != 0) && (cnt_q == c_TMAX)) begin
                    state_d = ERR;
                end else if (cnt_q != c_TMAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RCAP: begin
                rdata_d = m_rdata;
                state_d = DONE;
            end
            DONE, ERR: begin
                ptr_d   = (owner_q == c_LAST) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        ack_d = '0;
        err_d = '0;
        if (state_d == DONE) begin
            ack_d[owner_q] = 1'b1;
        end
        if (state_d == ERR) begin
            err_d[owner_q] = 1'b1;
        end
        busy_d    = (state_d != IDLE);
        m_sel_d   = (state_d == ISSUE);
        m_wr_d    = m_sel_d & wr_d;
        m_addr_d  = m_sel_d ? addr_d  : '0;
        m_wdata_d = m_sel_d ? wdata_d : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            m_sel_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            m_sel_q   <= m_sel_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign m_sel   = m_sel_q;
    assign m_wr    = m_wr_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bus_arbiter
// Description : Self-checking bench for reg_bus_arbiter. A transaction-level
//               reference model predicts every output each cycle; directed
//               scenarios pin literal latencies, grant order, timeout and
//               reset behaviour, then randomized traffic runs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_reg_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 15;

    logic              clk;
    logic              rstn;
    logic [N-1:0]      req;
    logic [N-1:0]      req_wr;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      ack;
    logic [N-1:0]      err;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic              m_sel;
    logic              m_wr;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW-1:0]     m_rdata;
    logic              m_ready;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bus_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .m_sel     (m_sel),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the expected value of every output for the
    // cycle that follows each edge, derived from the transaction rules.
    // ------------------------------------------------------------------
    logic          e_sel, e_wr, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [N-1:0]  e_ack, e_err, done_mask;
    logic          t_wr;
    int            t_owner, sel_run, m_ptr, cand;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e_sel = 0; e_wr = 0; e_busy = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
            e_ack = '0; e_err = '0; done_mask = '0;
            t_wr = 0; t_owner = 0; sel_run = 0; m_ptr = 0; cand = 0;
        end else begin
            done_mask = e_ack | e_err;
            if (done_mask != '0) begin
                // Completion cycle just ended: one idle cycle, rotate past owner.
                m_ptr   = (t_owner + 1) % N;
                e_ack   = '0;
                e_err   = '0;
                e_rdata = '0;
                e_busy  = 0;
            end else if (!e_busy) begin
                for (int k = 0; k < N; k++) begin
                    cand = (m_ptr + k) % N;
                    if (req[cand] && !e_busy) begin
                        t_owner = cand;
                        t_wr    = req_wr[cand];
                        e_addr  = req_addr[cand*AW +: AW];
                        e_wdata = req_wdata[cand*DW +: DW];
                        e_wr    = t_wr;
                        e_sel   = 1;
                        e_busy  = 1;
                        sel_run = 1;
                    end
                end
            end else if (e_sel) begin
                if (m_ready) begin
                    e_sel = 0; e_wr = 0; e_wdata = '0;
                    if (t_wr) e_ack[t_owner] = 1'b1;
                end else if (TO != 0 && sel_run == TO + 1) begin
                    e_sel = 0; e_wr = 0; e_wdata = '0;
                    e_err[t_owner] = 1'b1;
                end else begin
                    sel_run++;
                end
            end else begin
                // Read data capture cycle.
                e_rdata = m_rdata;
                e_ack[t_owner] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("m_sel", 32'(m_sel), 32'(e_sel));
            chk("m_wr", 32'(m_wr), 32'(e_wr));
            chk("m_wdata", 32'(m_wdata), 32'(e_sel ? e_wdata : '0));
            if (e_sel) chk("m_addr", 32'(m_addr), 32'(e_addr));
            chk("ack", 32'(ack), 32'(e_ack));
            chk("err", 32'(err), 32'(e_err));
            chk("busy", 32'(busy), 32'(e_busy));
            if ((e_ack != '0 && !t_wr) || e_err != '0) chk("rdata", 32'(rdata), 32'(e_rdata));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        m_ready = 1'b0; m_rdata = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    // Waits (bounded) for the first ack/err cycle and checks ack against want.
    task automatic wait_ack(input string name, input logic [N-1:0] want);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (ack != '0 || err != '0) begin
                seen = 1'b1;
                chk(name, 32'(ack), 32'(want));
            end
        end
        chk({name, "_seen"}, 32'(seen), 32'd1);
    endtask

    int got[$];
    int sel_cnt, ack_cnt, stall_left;
    logic got_err;

    initial begin
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        rstn = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_m_sel", 32'(m_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);

        // Single write from master 0
        tick();
        m_ready = 1'b1;
        set_req(0, 1'b1, 8'h10, 16'hBEEF);
        @(negedge clk);
        chk("w_T_sel", 32'(m_sel), 32'd0);
        @(negedge clk);
        chk("w_T1_sel", 32'(m_sel), 32'd1);
        chk("w_T1_wr", 32'(m_wr), 32'd1);
        chk("w_T1_addr", 32'(m_addr), 32'h10);
        chk("w_T1_wdata", 32'(m_wdata), 32'hBEEF);
        @(negedge clk);
        chk("w_T2_sel", 32'(m_sel), 32'd0);
        chk("w_T2_ack", 32'(ack), 32'h1);
        tick();
        req[0] = 1'b0;

        // Single read from master 2
        m_rdata = 16'hBEEF;
        set_req(2, 1'b0, 8'h10, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        chk("r_T1_sel", 32'(m_sel), 32'd1);
        chk("r_T1_wr", 32'(m_wr), 32'd0);
        @(negedge clk);
        chk("r_T2_sel", 32'(m_sel), 32'd0);
        chk("r_T2_ack", 32'(ack), 32'd0);
        @(negedge clk);
        chk("r_T3_ack", 32'(ack), 32'h4);
        chk("r_T3_rdata", 32'(rdata), 32'hBEEF);
        tick();
        req[2] = 1'b0;

        // All four held: strict rotation from pointer 0
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(8'h20 + i), DW'(16'h100 + i));
        got.delete();
        for (int c = 0; c < 60 && got.size() < 5; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) if (ack[b]) got.push_back(b);
        end
        tick();
        req = '0;
        chk("rr_count", 32'(got.size()), 32'd5);
        if (got.size() >= 5) begin
            chk("rr_g0", 32'(got[0]), 32'd0);
            chk("rr_g1", 32'(got[1]), 32'd1);
            chk("rr_g2", 32'(got[2]), 32'd2);
            chk("rr_g3", 32'(got[3]), 32'd3);
            chk("rr_g4", 32'(got[4]), 32'd0);
        end

        // Timeout: slave never ready
        do_reset();
        set_req(1, 1'b0, 8'h33, 16'h0);
        sel_cnt = 0; ack_cnt = 0; got_err = 1'b0;
        for (int c = 0; c < 40 && !got_err; c++) begin
            @(negedge clk);
            if (m_sel) sel_cnt++;
            if (ack != '0) ack_cnt++;
            if (err != '0) begin
                got_err = 1'b1;
                chk("to_err", 32'(err), 32'h2);
                chk("to_rdata", 32'(rdata), 32'd0);
            end
        end
        chk("to_seen", 32'(got_err), 32'd1);
        chk("to_sel_cycles", 32'(sel_cnt), 32'd16);
        chk("to_no_ack", 32'(ack_cnt), 32'd0);
        tick();
        req[1] = 1'b0;
        // Pointer moved past master 1, so master 2 now beats master 1.
        m_ready = 1'b1;
        set_req(1, 1'b1, 8'h01, 16'h1111);
        set_req(2, 1'b1, 8'h02, 16'h2222);
        wait_ack("to_ptr_adv", 4'b0100);
        tick();
        req = '0;

        // Ready low three ISSUE cycles then high
        do_reset();
        tick();
        set_req(3, 1'b1, 8'h22, 16'h1234);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) m_ready = 1'b1;
            @(negedge clk);
            chk("st_sel", 32'(m_sel), 32'd1);
            chk("st_err", 32'(err), 32'd0);
        end
        @(negedge clk);
        chk("st_ack", 32'(ack), 32'h8);
        chk("st_err_end", 32'(err), 32'd0);
        chk("st_sel_end", 32'(m_sel), 32'd0);
        tick();
        req[3] = 1'b0;

        // Reset in the middle of ISSUE
        do_reset();
        tick();
        set_req(2, 1'b0, 8'h44, 16'h0);
        tick();
        @(negedge clk);
        chk("mr_sel_before", 32'(m_sel), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mr_sel_async", 32'(m_sel), 32'd0);
        chk("mr_busy_async", 32'(busy), 32'd0);
        chk("mr_ack_async", 32'(ack | err), 32'd0);
        req = '0;
        tick();
        rstn = 1'b1;
        m_ready = 1'b1;
        set_req(1, 1'b1, 8'h55, 16'h5555);
        set_req(2, 1'b1, 8'h66, 16'h6666);
        wait_ack("mr_from_ptr0", 4'b0010);
        tick();
        req = '0;

        // Randomized traffic against the model
        do_reset();
        stall_left = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (req[i] && done_mask[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
                end
            end
            m_rdata = DW'($urandom);
            if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 40) == 0) begin
                stall_left = $urandom_range(10, 22);
                m_ready = 1'b0;
            end else begin
                m_ready = ($urandom_range(0, 3) != 0);
            end
        end
        tick();
        clear_inputs();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
